// File: rtl/axi_lite_sram_pkg.sv
// Shared types and constants for the AXI-Lite SRAM slave.
package axi_lite_sram_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Latency counters hold LATENCY-1, latency range is 1..8
    localparam int LAT_CNT_W = 3;

    localparam int BYTE_BITS = 8;

endpackage

// File: rtl/sram_bytewrite.sv
// Single-port-write / single-port-read synchronous RAM with byte enables.
// Read port is write-first: a same-cycle write to the read word is forwarded.
module sram_bytewrite
    import axi_lite_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int BE_WIDTH  = DATA_WIDTH / BYTE_BITS,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [BE_WIDTH-1:0]   i_be,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-masked write and write-first registered read
    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < BE_WIDTH; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_waddr][b*BYTE_BITS +: BYTE_BITS] <= i_wdata[b*BYTE_BITS +: BYTE_BITS];
            end
            if (i_re) begin
                if (i_we && i_be[b] && (i_waddr == i_raddr)) begin
                    r_rdata[b*BYTE_BITS +: BYTE_BITS] <= i_wdata[b*BYTE_BITS +: BYTE_BITS];
                end else begin
                    r_rdata[b*BYTE_BITS +: BYTE_BITS] <= r_mem[i_raddr][b*BYTE_BITS +: BYTE_BITS];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave backed by a byte-writable SRAM, with independent
// write and read FSMs and configurable response latencies.
module axi_lite_sram
    import axi_lite_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int PROT_WIDTH = 3,
    parameter int RESP_WIDTH = 2,
    parameter int DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0000_0000),
    parameter int RD_LATENCY = 1,
    parameter int WR_LATENCY = 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [PROT_WIDTH-1:0] s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [RESP_WIDTH-1:0] s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [PROT_WIDTH-1:0] s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [RESP_WIDTH-1:0] s_axi_rresp
);

    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * STRB_WIDTH);

    w_state_t              r_wstate;
    r_state_t              r_rstate;
    logic                  r_awready, r_wready, r_arready;
    logic                  r_aw_done, r_w_done;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [LAT_CNT_W-1:0]  r_wcnt, r_rcnt;
    logic                  r_bvalid, r_rvalid, r_rok;
    logic [RESP_WIDTH-1:0] r_bresp, r_rresp;

    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic [ADDR_WIDTH-1:0] w_aw_off, w_ar_off;
    logic                  w_aw_in_range, w_ar_in_range;
    logic [IDX_W-1:0]      w_aw_idx, w_ar_idx;
    logic                  w_commit, w_rsample;
    logic [DATA_WIDTH-1:0] w_sram_rdata;
    logic                  w_unused_prot;

    assign w_unused_prot = ^{s_axi_awprot, s_axi_arprot};

    assign w_aw_hs = s_axi_awvalid && r_awready;
    assign w_w_hs  = s_axi_wvalid && r_wready;
    assign w_ar_hs = s_axi_arvalid && r_arready;

    assign w_aw_off      = r_awaddr - BASE_ADDR;
    assign w_ar_off      = r_araddr - BASE_ADDR;
    assign w_aw_in_range = (r_awaddr >= BASE_ADDR) && (w_aw_off < SPAN);
    assign w_ar_in_range = (r_araddr >= BASE_ADDR) && (w_ar_off < SPAN);
    assign w_aw_idx      = w_aw_off[BYTE_SHIFT +: IDX_W];
    assign w_ar_idx      = w_ar_off[BYTE_SHIFT +: IDX_W];

    assign w_commit  = (r_wstate == W_WAIT) && (r_wcnt == '0);
    assign w_rsample = (r_rstate == R_WAIT) && (r_rcnt == '0);

    sram_bytewrite #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .i_clk   (aclk),
        .i_we    (w_commit && w_aw_in_range),
        .i_be    (r_wstrb),
        .i_waddr (w_aw_idx),
        .i_wdata (r_wdata),
        .i_re    (w_rsample),
        .i_raddr (w_ar_idx),
        .o_rdata (w_sram_rdata)
    );

    // Write FSM: capture AW and W in any order, wait, commit, respond
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wcnt    <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= s_axi_awaddr;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_axi_wdata;
                        r_wstrb  <= s_axi_wstrb;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_wstate  <= W_WAIT;
                        r_wcnt    <= LAT_CNT_W'(WR_LATENCY - 1);
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_awready <= !(r_aw_done || w_aw_hs);
                        r_wready  <= !(r_w_done || w_w_hs);
                    end
                end
                W_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_aw_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_wstate  <= W_IDLE;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: accept AR, wait RD_LATENCY cycles, present data until rready
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_araddr  <= '0;
            r_rcnt    <= '0;
            r_rvalid  <= 1'b0;
            r_rok     <= 1'b0;
            r_rresp   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr  <= s_axi_araddr;
                        r_rstate  <= R_WAIT;
                        r_rcnt    <= LAT_CNT_W'(RD_LATENCY - 1);
                        r_arready <= 1'b0;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_rcnt == '0) begin
                        r_rstate <= R_DATA;
                        r_rvalid <= 1'b1;
                        r_rok    <= w_ar_in_range;
                        r_rresp  <= w_ar_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
                    end else begin
                        r_rcnt <= r_rcnt - 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_arready = r_arready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    // The RAM output register holds the sampled word (no further reads while
    // in R_DATA); gating keeps rdata zero in reset, idle and on SLVERR.
    assign s_axi_rdata   = (r_rvalid && r_rok) ? w_sram_rdata : '0;

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench: two instances (latency 1/1 at base 0, latency 4/3 at
// base 0x4000) driven by directed and random transactions against a word model.
module tb_axi_lite_sram;

    logic        aclk = 1'b0;
    logic        areset [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2];
    logic        bvalid [2], bready [2], arvalid [2], arready [2];
    logic        rvalid [2], rready [2];
    logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];
    logic [2:0]  prot = 3'b101;

    logic [31:0] model [2][1024];
    int          n_total = 0;
    int          n_pass  = 0;

    always #5 aclk = ~aclk;

    axi_lite_sram #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (1024),
        .BASE_ADDR  (32'h0000_0000), .RD_LATENCY (1), .WR_LATENCY (1)
    ) u_dut_a (
        .aclk (aclk), .areset (areset[0]),
        .s_axi_awvalid (awvalid[0]), .s_axi_awready (awready[0]),
        .s_axi_awaddr (awaddr[0]), .s_axi_awprot (prot),
        .s_axi_wvalid (wvalid[0]), .s_axi_wready (wready[0]),
        .s_axi_wdata (wdata[0]), .s_axi_wstrb (wstrb[0]),
        .s_axi_bvalid (bvalid[0]), .s_axi_bready (bready[0]), .s_axi_bresp (bresp[0]),
        .s_axi_arvalid (arvalid[0]), .s_axi_arready (arready[0]),
        .s_axi_araddr (araddr[0]), .s_axi_arprot (prot),
        .s_axi_rvalid (rvalid[0]), .s_axi_rready (rready[0]),
        .s_axi_rdata (rdata[0]), .s_axi_rresp (rresp[0])
    );

    axi_lite_sram #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .DEPTH (256),
        .BASE_ADDR  (32'h0000_4000), .RD_LATENCY (4), .WR_LATENCY (3)
    ) u_dut_b (
        .aclk (aclk), .areset (areset[1]),
        .s_axi_awvalid (awvalid[1]), .s_axi_awready (awready[1]),
        .s_axi_awaddr (awaddr[1]), .s_axi_awprot (prot),
        .s_axi_wvalid (wvalid[1]), .s_axi_wready (wready[1]),
        .s_axi_wdata (wdata[1]), .s_axi_wstrb (wstrb[1]),
        .s_axi_bvalid (bvalid[1]), .s_axi_bready (bready[1]), .s_axi_bresp (bresp[1]),
        .s_axi_arvalid (arvalid[1]), .s_axi_arready (arready[1]),
        .s_axi_araddr (araddr[1]), .s_axi_arprot (prot),
        .s_axi_rvalid (rvalid[1]), .s_axi_rready (rready[1]),
        .s_axi_rdata (rdata[1]), .s_axi_rresp (rresp[1])
    );

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h0000_4000;
    endfunction

    function automatic int unsigned depth_of(input int d);
        return (d == 0) ? 1024 : 256;
    endfunction

    function automatic int rlat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int wlat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit in_rng(input int d, input logic [31:0] a);
        return (a >= base_of(d)) && (a < base_of(d) + depth_of(d) * 4);
    endfunction

    function automatic int unsigned widx(input int d, input logic [31:0] a);
        return (a - base_of(d)) / 4;
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [31:0] a);
        return in_rng(d, a) ? model[d][widx(d, a)] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input int d, input logic [31:0] a);
        return in_rng(d, a) ? 2'b00 : 2'b10;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_bus(input int d);
        awvalid[d] = 1'b0; wvalid[d] = 1'b0; bready[d] = 1'b0;
        arvalid[d] = 1'b0; rready[d] = 1'b0;
        awaddr[d] = '0; wdata[d] = '0; wstrb[d] = '0; araddr[d] = '0;
    endtask

    task automatic do_reset(input int d);
        @(negedge aclk);
        areset[d] = 1'b1;
        idle_bus(d);
        repeat (2) @(negedge aclk);
        check("rst_awready", awready[d], 0);
        check("rst_wready", wready[d], 0);
        check("rst_arready", arready[d], 0);
        check("rst_bvalid", bvalid[d], 0);
        check("rst_rvalid", rvalid[d], 0);
        check("rst_bresp", bresp[d], 0);
        check("rst_rresp", rresp[d], 0);
        check("rst_rdata", rdata[d], 0);
        areset[d] = 1'b0;
        #1;
        check("rel_awready_pre", awready[d], 0);
        @(negedge aclk);
        check("rel_awready", awready[d], 1);
        check("rel_wready", wready[d], 1);
        check("rel_arready", arready[d], 1);
    endtask

    // order: 0 AW and W together, 1 AW first, 2 W first
    task automatic axi_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int order, input int hold,
                             input string tag);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int cyc = 0;
        logic [1:0] er = exp_resp(d, addr);
        @(negedge aclk);
        awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
        if (order != 2) awvalid[d] = 1'b1;
        if (order != 1) wvalid[d] = 1'b1;
        while (!(aw_done && w_done) && cyc < 30) begin
            aw_fire = awvalid[d] && awready[d];
            w_fire  = wvalid[d] && wready[d];
            @(posedge aclk);
            @(negedge aclk);
            cyc++;
            if (aw_fire) begin awvalid[d] = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid[d] = 1'b0; w_done = 1; end
            if (aw_done && !w_done) begin
                check({tag, "_awready_held"}, awready[d], 0);
                wvalid[d] = 1'b1;
            end
            if (w_done && !aw_done) begin
                check({tag, "_wready_held"}, wready[d], 0);
                awvalid[d] = 1'b1;
            end
        end
        check({tag, "_captured"}, {aw_done, w_done}, 2'b11);
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        cyc = 0;
        while (!bvalid[d] && cyc < 20) begin
            check({tag, "_awready_wait"}, {awready[d], wready[d]}, 2'b00);
            @(negedge aclk);
            cyc++;
        end
        check({tag, "_blat"}, cyc, wlat(d));
        if (er == 2'b00) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[d][widx(d, addr)][8*b +: 8] = data[8*b +: 8];
        end
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_bvalid"}, bvalid[d], 1);
            check({tag, "_bresp"}, bresp[d], er);
            check({tag, "_awready_resp"}, {awready[d], wready[d]}, 2'b00);
            if (h < hold) @(negedge aclk);
        end
        bready[d] = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready[d] = 1'b0;
        check({tag, "_bvalid_done"}, bvalid[d], 0);
        check({tag, "_ready_back"}, {awready[d], wready[d]}, 2'b11);
    endtask

    task automatic axi_read(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] er, input int hold, input string tag);
        int cyc = 0;
        @(negedge aclk);
        araddr[d] = addr;
        arvalid[d] = 1'b1;
        while (!arready[d] && cyc < 20) begin
            @(negedge aclk);
            cyc++;
        end
        check({tag, "_arready"}, arready[d], 1);
        @(posedge aclk);
        @(negedge aclk);
        arvalid[d] = 1'b0;
        cyc = 0;
        while (!rvalid[d] && cyc < 20) begin
            check({tag, "_arready_wait"}, arready[d], 0);
            @(negedge aclk);
            cyc++;
        end
        check({tag, "_rlat"}, cyc, rlat(d));
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_rvalid"}, rvalid[d], 1);
            check({tag, "_rdata"}, rdata[d], exp_data);
            check({tag, "_rresp"}, rresp[d], er);
            check({tag, "_arready_data"}, arready[d], 0);
            if (h < hold) @(negedge aclk);
        end
        rready[d] = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rready[d] = 1'b0;
        check({tag, "_rvalid_done"}, rvalid[d], 0);
        check({tag, "_arready_back"}, arready[d], 1);
    endtask

    task automatic random_ops(input int d, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < 80) begin
                a = base_of(d) + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            end else if (d == 1 && $urandom_range(0, 1) == 0) begin
                a = 32'h0000_3FC0 + 4 * $urandom_range(0, 15);
            end else begin
                a = base_of(d) + depth_of(d) * 4 + 4 * $urandom_range(0, 15);
            end
            if ($urandom_range(0, 1) == 0)
                axi_write(d, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                          $urandom_range(0, 3), "rnd_wr");
            else
                axi_read(d, a, exp_rd(d, a), exp_resp(d, a), $urandom_range(0, 3), "rnd_rd");
        end
    endtask

    logic [31:0] old_val;

    initial begin
        areset[0] = 1'b1; areset[1] = 1'b1;
        idle_bus(0); idle_bus(1);
        do_reset(0);
        do_reset(1);

        // Instance A: latency 1/1, base 0
        for (int w = 0; w < 16; w++)
            axi_write(0, 4 * w, $urandom, 4'hF, w % 3, 0, "init_a");
        axi_write(0, 32'h10, 32'h1234_5678, 4'hF, 0, 0, "init_10");

        axi_write(0, 32'h4, 32'hAA55_AA55, 4'hF, 1, 0, "wr04");
        axi_read(0, 32'h4, 32'hAA55_AA55, 2'b00, 0, "rd04");

        axi_write(0, 32'h8, 32'hFFFF_FFFF, 4'hF, 0, 0, "wr08_full");
        axi_write(0, 32'h8, 32'h1122_3344, 4'b0101, 2, 2, "wr08_strb");
        axi_read(0, 32'h8, 32'hFF22_FF44, 2'b00, 1, "rd08");

        axi_write(0, 32'hC, 32'h0BAD_0BAD, 4'h0, 0, 0, "wr0c_nostrb");
        axi_read(0, 32'hC, exp_rd(0, 32'hC), 2'b00, 0, "rd0c");

        axi_read(0, 32'h1000, 32'h0, 2'b10, 2, "rd_oor");
        axi_write(0, 32'h1000, 32'hCAFE_F00D, 4'hF, 0, 1, "wr_oor");
        axi_read(0, 32'h0, exp_rd(0, 32'h0), 2'b00, 0, "rd_alias0");
        axi_read(0, 32'hFFC, exp_rd(0, 32'hFFC) , 2'b00, 0, "rd_top_pre");
        axi_write(0, 32'hFFF, 32'h5A5A_0001, 4'hF, 0, 0, "wr_top");
        axi_read(0, 32'hFFC, 32'h5A5A_0001, 2'b00, 0, "rd_top");

        // Write commit and read sample land on the same edge
        fork
            axi_write(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, "wf_wr");
            axi_read(0, 32'h10, 32'hDEAD_BEEF, 2'b00, 0, "wf_rd");
        join

        // Reset while the write sits in W_WAIT
        old_val = model[0][8];
        @(negedge aclk);
        check("r36_ready", {awready[0], wready[0]}, 2'b11);
        awaddr[0] = 32'h20; wdata[0] = ~old_val; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        check("r36_captured", {awready[0], wready[0]}, 2'b00);
        areset[0] = 1'b1;
        #1;
        check("r36_bvalid", bvalid[0], 0);
        check("r36_awready_rst", awready[0], 0);
        repeat (2) @(negedge aclk);
        check("r36_bvalid_held", bvalid[0], 0);
        areset[0] = 1'b0;
        #1;
        check("r36_awready_rel", awready[0], 0);
        @(negedge aclk);
        check("r36_awready_1cyc", awready[0], 1);
        axi_read(0, 32'h20, old_val, 2'b00, 0, "r36_rd");

        random_ops(0, 60);

        // Instance B: latency 4/3, base 0x4000, 256 words
        for (int w = 0; w < 16; w++)
            axi_write(1, 32'h4000 + 4 * w, $urandom, 4'hF, 2 - (w % 3), 0, "init_b");
        axi_write(1, 32'h43FC, 32'h7777_8888, 4'hF, 1, 0, "b_wr_top");
        axi_read(1, 32'h43FC, 32'h7777_8888, 2'b00, 0, "b_rd_top");
        axi_write(1, 32'h4010, 32'hA1B2_C3D4, 4'hF, 0, 1, "b_wr10");
        axi_read(1, 32'h4010, 32'hA1B2_C3D4, 2'b00, 3, "b_rd_hold");
        axi_read(1, 32'h3FFC, 32'h0, 2'b10, 0, "b_rd_below");
        axi_write(1, 32'h4400, 32'h1357_9BDF, 4'hF, 2, 0, "b_wr_above");
        axi_read(1, 32'h4000, exp_rd(1, 32'h4000), 2'b00, 0, "b_rd_alias0");

        random_ops(1, 60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_sram.md
AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 SHALL have parameter PROT_WIDTH, default 3, and parameter RESP_WIDTH, default 2.
REQ-005 SHALL have parameter DEPTH, default 1024, number of DATA_WIDTH words; power of two.
REQ-006 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; DEPTH*STRB_WIDTH aligned.
REQ-007 SHALL have parameter RD_LATENCY, default 1, range 1..8, cycles from AR handshake to rvalid.
REQ-008 SHALL have parameter WR_LATENCY, default 1, range 1..8, cycles from write capture to bvalid.
REQ-009 SHALL have ports: aclk in 1 clock; areset in 1 asynchronous active-high reset.
REQ-010 SHALL have ports s_axi_awvalid in 1, s_axi_awready out 1, s_axi_awaddr in ADDR_WIDTH, s_axi_awprot in PROT_WIDTH (ignored).
REQ-011 SHALL have ports s_axi_wvalid in 1, s_axi_wready out 1, s_axi_wdata in DATA_WIDTH, s_axi_wstrb in STRB_WIDTH.
REQ-012 SHALL have ports s_axi_bvalid out 1, s_axi_bready in 1, s_axi_bresp out RESP_WIDTH.
REQ-013 SHALL have ports s_axi_arvalid in 1, s_axi_arready out 1, s_axi_araddr in ADDR_WIDTH, s_axi_arprot in PROT_WIDTH (ignored).
REQ-014 SHALL have ports s_axi_rvalid out 1, s_axi_rready in 1, s_axi_rdata out DATA_WIDTH, s_axi_rresp out RESP_WIDTH.

Function
REQ-015 Write FSM states SHALL be W_IDLE, W_WAIT, W_RESP; read FSM states SHALL be R_IDLE, R_WAIT, R_DATA; the two FSMs SHALL run independently.
REQ-016 In W_IDLE, awready SHALL be high until AW is captured and wready high until W is captured; AW and W SHALL be accepted in either order or in the same cycle.
REQ-017 Once both are captured, the FSM SHALL enter W_WAIT and count WR_LATENCY cycles; at expiry it SHALL commit the write and enter W_RESP with bvalid high.
REQ-018 The write commit SHALL update only the bytes whose wstrb bit is 1; wstrb = 0 SHALL leave memory unchanged and respond OKAY.
REQ-019 Word index SHALL be (addr - BASE_ADDR) >> log2(STRB_WIDTH); the low log2(STRB_WIDTH) address bits SHALL be ignored.
REQ-020 An address outside [BASE_ADDR, BASE_ADDR + DEPTH*STRB_WIDTH) SHALL give resp 2'b10 (SLVERR), with no write and rdata = 0; in-range accesses SHALL give 2'b00.
REQ-021 bvalid SHALL hold with a stable bresp until bready; the handshake SHALL return the FSM to W_IDLE, and the next AW/W SHALL be accepted no earlier than the following cycle.
REQ-022 In R_IDLE, arready SHALL be high; the AR handshake SHALL enter R_WAIT, and rvalid SHALL assert exactly RD_LATENCY cycles after the handshake.
REQ-023 rdata SHALL be sampled from memory on the cycle R_DATA is entered, and rdata/rresp SHALL hold stable until rready; the handshake SHALL return the FSM to R_IDLE.
REQ-024 If a write commit and a read sample hit the same word in the same cycle, the read SHALL return the newly written data (write-first).
REQ-025 arready SHALL be low in R_WAIT and R_DATA; awready and wready SHALL be low once their channel is captured and through W_RESP.

Reset
REQ-026 On areset high, asynchronously: FSMs to W_IDLE/R_IDLE; bvalid, rvalid = 0; awready, wready, arready = 0 while reset is held; bresp, rresp, rdata = 0; latency counters = 0.
REQ-027 awready, wready and arready SHALL go to 1 on the first aclk edge after areset deasserts.
REQ-028 Memory contents SHALL NOT be cleared by reset; a transaction interrupted by reset SHALL be discarded, and an uncommitted write SHALL not modify memory.

Structure
REQ-029 The FSM state enums and the OKAY/SLVERR response constants SHALL live in the shared AXI package.
REQ-030 The storage array SHALL be one sub-module, sram_bytewrite: 1 write port with byte enables and 1 read port, synchronous, write-first.

Verification
REQ-031 Write 0xAA55_AA55 to 0x4 with strb 4'hF, AW one cycle before W, RD_LATENCY=WR_LATENCY=1 -> bvalid 1 cycle after W capture, bresp 00; read 0x4 -> rvalid 1 cycle after AR, rdata 0xAA55_AA55.
REQ-032 Write 0x1122_3344 to 0x8 with strb 4'b0101 over 0xFFFF_FFFF -> read of 0x8 returns 0xFF22_FF44.
REQ-033 Read 0x0000_1000 with DEPTH=1024 -> rresp 10, rdata 0; write to 0x1000 -> bresp 10, memory unchanged.
REQ-034 RD_LATENCY=4, rready held low 3 cycles after rvalid -> rvalid 4 cycles after AR, rdata stable until rready, arready low throughout.
REQ-035 Same-cycle write commit and read sample to 0x10 with 0xDEAD_BEEF -> rdata 0xDEAD_BEEF.
REQ-036 areset asserted in W_WAIT -> bvalid 0 immediately, the target word keeps its old value, awready is 1 one cycle after release.
